// File: rtl/mu0_trace_if.sv
// mu0_trace_if: mu0 trace port bundle; slave = trace buffer (pc/ir/acc/trc_ready in; trc_valid/trc_data/count/overflow/drop_cnt/halted out), master = core+consumer side; REC_W grows by WIDTH when MU0_TRACE_TIMESTAMP_EN is defined
interface mu0_trace_if #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 4
);
`ifdef MU0_TRACE_TIMESTAMP_EN
  localparam int REC_W = 4*WIDTH;
`else
  localparam int REC_W = 3*WIDTH;
`endif
  logic [WIDTH-1:0]  pc;
  logic [WIDTH-1:0]  ir;
  logic [WIDTH-1:0]  acc;
  logic              trc_ready;
  logic              trc_valid;
  logic [REC_W-1:0]  trc_data;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic [7:0]        drop_cnt;
  logic              halted;
  modport slave  (input pc, ir, acc, trc_ready,
                  output trc_valid, trc_data, count, overflow, drop_cnt, halted);
  modport master (output pc, ir, acc, trc_ready,
                  input trc_valid, trc_data, count, overflow, drop_cnt, halted);
endinterface

// File: rtl/mu0_trace_buffer.sv
// mu0_trace_buffer: samples mu0 {pc,ir,acc} per instruction into a show-ahead FIFO, halts capture on STP; ports clk, reset, bus (mu0_trace_if.slave); MU0_TRACE_TIMESTAMP_EN appends a cycle timestamp
module mu0_trace_buffer #(
  parameter int       WIDTH  = 16,
  parameter int       DEPTH  = 16,
  parameter int       ADDR_W = 4,
  parameter bit [3:0] STP    = 4'b0111
) (
  input logic        clk,
  input logic        reset,
  mu0_trace_if.slave bus
);
`ifdef MU0_TRACE_TIMESTAMP_EN
  localparam int REC_W = 4*WIDTH;
`else
  localparam int REC_W = 3*WIDTH;
`endif
  typedef enum logic [1:0] {FIRST, RUN, HALT} state_t;
  state_t            state_q, state_d;
  logic [WIDTH-1:0]  pc_q;
  logic [ADDR_W-1:0] wr_q, rd_q;
  logic [ADDR_W:0]   count_q;
  logic              overflow_q, halted_q, halted_d;
  logic [7:0]        drop_q;
  logic [REC_W-1:0]  mem [DEPTH];
  logic [REC_W-1:0]  rec;
  logic              cap, stp_hit, pop, full, push, drop;
`ifdef MU0_TRACE_TIMESTAMP_EN
  logic [WIDTH-1:0]  ts_q;
  assign rec = {bus.pc, bus.ir, bus.acc, ts_q};
  always_ff @(posedge clk)
    ts_q <= reset ? '0 : ts_q + 1'b1;
`else
  assign rec = {bus.pc, bus.ir, bus.acc};
`endif
  always_comb begin
    cap      = (state_q == FIRST) || (state_q == RUN && bus.pc != pc_q);
    stp_hit  = cap && bus.ir[WIDTH-1 -: 4] == STP;
    state_d  = stp_hit ? HALT : (state_q == FIRST ? RUN : state_q);
    halted_d = halted_q | stp_hit;
  end
  // a full FIFO still accepts a push when the head leaves in the same cycle
  assign full = count_q == (ADDR_W+1)'(DEPTH);
  assign pop  = count_q != '0 && bus.trc_ready;
  assign push = cap && (!full || pop);
  assign drop = cap && full && !pop;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= FIRST;
      pc_q       <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      halted_q   <= halted_d;
      pc_q       <= state_q != HALT ? bus.pc : pc_q;
      wr_q       <= push ? wr_q + 1'b1 : wr_q;
      rd_q       <= pop ? rd_q + 1'b1 : rd_q;
      count_q    <= count_q + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
      overflow_q <= overflow_q | drop;
      drop_q     <= (drop && drop_q != 8'hFF) ? drop_q + 1'b1 : drop_q;
    end
  end
  always_ff @(posedge clk)
    if (push) mem[wr_q] <= rec;
  assign bus.trc_valid = count_q != '0;
  assign bus.trc_data  = count_q != '0 ? mem[rd_q] : '0;
  assign bus.count     = count_q;
  assign bus.overflow  = overflow_q;
  assign bus.drop_cnt  = drop_q;
  assign bus.halted    = halted_q;
endmodule
